// File: rtl/mult32_seq_if.sv
// Handshake and operand/result bundle for the sequential multiplier.
// The control unit drives the master side; mult32_seq takes the slave side.
interface mult32_seq_if #(
    parameter int WIDTH = 32
);
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             BUSY;
    logic             DONE;

    modport master (output START, A, B, input HI, LO, BUSY, DONE);
    modport slave  (input START, A, B, output HI, LO, BUSY, DONE);
endinterface

// File: rtl/mult32_seq.sv
// Multi-cycle shift-and-add multiplier: one WIDTH-bit ripple add per clock,
// accumulating a 2*WIDTH-bit product that is presented as HI:LO.
// Optional macro MULT_SIGNED_EN: two's-complement operands. Magnitudes are
// multiplied and the product is negated in an extra FIX cycle when the
// operand signs differ.
module mult32_seq #(
    parameter int WIDTH = 32
) (
    input  logic        CLK,
    input  logic        RST,
    mult32_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef MULT_SIGNED_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    // Half/full-adder ripple chain; carry-out returned in the MSB.
    function automatic logic [WIDTH:0] ripple_add(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic             cin);
        logic [WIDTH-1:0] s;
        logic             c;
        c = cin;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   run_sum;

    // Conditional add of the multiplicand; the carry bit is kept so that it
    // shifts into the accumulator rather than being lost.
    assign run_sum = acc_lo_q[0] ? ripple_add(acc_hi_q, mcand_q, 1'b0)
                                 : {1'b0, acc_hi_q};

`ifdef MULT_SIGNED_EN
    logic             neg_q, neg_d;

    // Two's-complement magnitude: invert and add 1 through the adder chain.
    // The most-negative value maps to 2^(WIDTH-1) read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] t;
        t = ripple_add(~x, {WIDTH{1'b0}}, 1'b1);
        return x[WIDTH-1] ? t[WIDTH-1:0] : x;
    endfunction

    // Negate the full product: the +1 ripples out of LO into HI.
    function automatic logic [2*WIDTH-1:0] negate2w(input logic [WIDTH-1:0] h,
                                                    input logic [WIDTH-1:0] l);
        logic [WIDTH:0] tl;
        logic [WIDTH:0] th;
        tl = ripple_add(~l, {WIDTH{1'b0}}, 1'b1);
        th = ripple_add(~h, {WIDTH{1'b0}}, tl[WIDTH]);
        return {th[WIDTH-1:0], tl[WIDTH-1:0]};
    endfunction
`endif

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MULT_SIGNED_EN
        neg_d    = neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
`ifdef MULT_SIGNED_EN
                    neg_d    = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                    mcand_d  = magnitude(bus.A);
                    acc_lo_d = magnitude(bus.B);
`else
                    mcand_d  = bus.A;
                    acc_lo_d = bus.B;
`endif
                    acc_hi_d = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                {acc_hi_d, acc_lo_d} = {run_sum, acc_lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
`ifdef MULT_SIGNED_EN
                    state_d = S_FIX;
`else
                    state_d = S_DONE;
                    hi_d    = acc_hi_d;
                    lo_d    = acc_lo_d;
`endif
                end
            end
`ifdef MULT_SIGNED_EN
            S_FIX: begin
                if (neg_q) begin
                    {acc_hi_d, acc_lo_d} = negate2w(acc_hi_q, acc_lo_q);
                end
                state_d = S_DONE;
                hi_d    = acc_hi_d;
                lo_d    = acc_lo_d;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef MULT_SIGNED_EN
        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
`else
        busy_d = (state_d == S_RUN);
`endif
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MULT_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MULT_SIGNED_EN
            neg_q    <= neg_d;
`endif
        end
    end

    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
endmodule

// File: tb/tb_mult32_seq.sv
// Scoreboard bench for mult32_seq: stimulus pushes expected results, a
// monitor pops and checks them on every DONE pulse.
module tb_mult32_seq;
`ifdef MULT_SIGNED_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif
    localparam int NV = 5;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    exp_t        sb[$];
    logic        prev_done = 1'b0;
    int          busy_cnt = 0;

    logic [31:0] va [NV];
    logic [31:0] vb [NV];
    logic [31:0] vhi[NV];
    logic [31:0] vlo[NV];

    mult32_seq_if #(.WIDTH(32)) bus ();
    mult32_seq #(.WIDTH(32)) dut (.CLK(clk), .RST(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present operands at a falling edge; the next rising edge accepts them.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        bus.A = a;
        bus.B = b;
        bus.START = 1'b1;
        @(posedge clk);
        #1;
        e.hi = eh; e.lo = el; e.cyc = cyc;
        sb.push_back(e);
        bus.START = 1'b0;
    endtask

    // Wait for DONE, then step into the following IDLE cycle.
    task automatic wait_done();
        int n = 0;
        while (!bus.DONE && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.DONE) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no DONE expected DONE within 200 cycles");
        end
        @(negedge clk);
    endtask

    // Monitor: checks every DONE against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                if (prev_done) chk("done_one_cycle", 64'(bus.DONE), 64'd0);
                if (bus.BUSY) busy_cnt++;
                if (bus.DONE) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got DONE hi=%0h lo=%0h expected none",
                                 bus.HI, bus.LO);
                    end else begin
                        e = sb.pop_front();
                        chk("hi", 64'(bus.HI), 64'(e.hi));
                        chk("lo", 64'(bus.LO), 64'(e.lo));
                        chk("latency", 64'(cyc - e.cyc), 64'(LAT));
                        chk("busy_cycles", 64'(busy_cnt), 64'(LAT));
                        chk("busy_at_done", 64'(bus.BUSY), 64'd0);
                    end
                    busy_cnt = 0;
                end
                prev_done = bus.DONE;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef MULT_SIGNED_EN
        va[0] = 32'hFFFFFFFD; vb[0] = 32'h00000005; vhi[0] = 32'hFFFFFFFF; vlo[0] = 32'hFFFFFFF1;
        va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF; vhi[1] = 32'h00000000; vlo[1] = 32'h00000001;
        va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF; vhi[2] = 32'h00000000; vlo[2] = 32'h80000000;
        va[3] = 32'h00000000; vb[3] = 32'h80000000; vhi[3] = 32'h00000000; vlo[3] = 32'h00000000;
        va[4] = 32'h80000000; vb[4] = 32'h80000000; vhi[4] = 32'h40000000; vlo[4] = 32'h00000000;
`else
        va[0] = 32'h00000003; vb[0] = 32'h00000005; vhi[0] = 32'h00000000; vlo[0] = 32'h0000000F;
        va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF; vhi[1] = 32'hFFFFFFFE; vlo[1] = 32'h00000001;
        va[2] = 32'h00000000; vb[2] = 32'hDEADBEEF; vhi[2] = 32'h00000000; vlo[2] = 32'h00000000;
        va[3] = 32'h12345678; vb[3] = 32'h00000010; vhi[3] = 32'h00000001; vlo[3] = 32'h23456780;
        va[4] = 32'h80000000; vb[4] = 32'h80000000; vhi[4] = 32'h40000000; vlo[4] = 32'h00000000;
`endif
        rst_n = 1'b0;
        bus.START = 1'b0;
        bus.A = '0;
        bus.B = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi", 64'(bus.HI), 64'd0);
        chk("rst_lo", 64'(bus.LO), 64'd0);
        chk("rst_busy", 64'(bus.BUSY), 64'd0);
        chk("rst_done", 64'(bus.DONE), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, back to back at the earliest accepted slot.
        for (int i = 0; i < NV; i++) begin
            issue(va[i], vb[i], vhi[i], vlo[i]);
            wait_done();
        end

        // START held high, operands changed mid-run: one DONE for the
        // original operands, the next acceptance only after DONE.
        bus.A = 32'd2;
        bus.B = 32'd9;
        bus.START = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{hi: 32'h0, lo: 32'h12, cyc: cyc});
        repeat (10) @(posedge clk);
        #1;
        bus.A = 32'h100;
        bus.B = 32'h100;
        begin
            int n = 0;
            while (!bus.DONE && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        sb.push_back('{hi: 32'h0, lo: 32'h10000, cyc: cyc});
        bus.START = 1'b0;
        wait_done();

        // Asynchronous reset in the middle of RUN aborts without DONE.
        issue(32'h11, 32'h22, 32'h0, 32'h242);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_hi", 64'(bus.HI), 64'd0);
        chk("abort_lo", 64'(bus.LO), 64'd0);
        chk("abort_busy", 64'(bus.BUSY), 64'd0);
        chk("abort_done", 64'(bus.DONE), 64'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 5) @(negedge clk);
        issue(32'd7, 32'd6, 32'h0, 32'h2A);
        wait_done();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult32_seq.md
Name: mult32_seq

Overview:
- Multi-cycle shift-and-add multiplier that consumes the sum/carry outputs of the half/full-adder ripple chain.
- One WIDTH-bit add is performed per clock, accumulating a 2*WIDTH-bit product as HI:LO.
- Used by the ALU as a low-area alternative to the combinational multiplier.
- START/DONE handshake toward the control unit.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits split into HI (upper WIDTH) and LO (lower WIDTH).

Ports:
- CLK  input  1  system clock, rising-edge active
- RST  input  1  asynchronous, active-low reset
- START  input  1  request; sampled only in IDLE
- A  input  WIDTH  multiplicand
- B  input  WIDTH  multiplier
- HI  output  WIDTH  upper product word
- LO  output  WIDTH  lower product word
- BUSY  output  1  high in RUN and FIX states
- DONE  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-low. RST=0 forces state=IDLE, HI=0, LO=0, BUSY=0, DONE=0, cnt=0 immediately, without waiting for a clock edge.
- Reset mid-operation: the operation is aborted and no DONE is issued. After release, the block waits for a new START.
- States: IDLE, RUN, FIX (present only with the optional feature), DONE.
- IDLE, START=1 at an edge:
  - Latch mcand=A.
  - Load {acc_hi, acc_lo} = {0, B}.
  - cnt=0; go to RUN.
  - BUSY rises in the following cycle.
- IDLE, START=0: hold; HI/LO keep the last product.
- RUN, one iteration per edge:
  - If acc_lo[0]=1: {c, s} = acc_hi + mcand, computed as a WIDTH-bit ripple add with carry-out c. Otherwise {c, s} = {0, acc_hi}.
  - Then {acc_hi, acc_lo} = {c, s, acc_lo[WIDTH-1:1]}, i.e. a logical right shift of the WIDTH+1-bit sum into the accumulator.
  - cnt increments; at cnt=WIDTH-1 go to DONE, or to FIX if that state is enabled.
- The carry-out must never be dropped. Example: 0xFFFFFFFF * 0xFFFFFFFF = 0xFFFFFFFE_00000001.
- DONE state (one cycle):
  - HI=acc_hi, LO=acc_lo, DONE=1, BUSY=0.
  - Next edge returns to IDLE unconditionally.
- HI/LO are registered and update only on entry to DONE. They hold the product until the next DONE or reset.
- Latency: START sampled at edge t gives DONE high in the cycle after edge t+WIDTH (32 RUN edges); t+WIDTH+1 when FIX is enabled.
- Throughput: a new START is accepted earliest one cycle after DONE.
- START asserted while BUSY or DONE: ignored, not queued.
- A/B changes after acceptance: no effect on the operation in progress.
- Zero operand: still takes the full latency; result 0.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined, signed two's-complement multiply:
  - On acceptance, latch neg = A[WIDTH-1] ^ B[WIDTH-1].
  - Load |A| and |B| using the adder with inverted operand plus carry-in=1.
  - After the last RUN iteration, enter FIX for one cycle. If neg=1, the 2*WIDTH product is negated (invert, add 1 rippled through LO into HI), then go to DONE.
  - The most-negative operand is handled as an unsigned magnitude of 2^(WIDTH-1). Example: 0x80000000 * 0x80000000 = 0x40000000_00000000.
- Undefined, unsigned multiply:
  - The FIX state and negation logic are absent.
  - Latency is WIDTH cycles.

Test Plan:
- Reset, then A=0x00000003, B=0x00000005, START pulse -> BUSY for 32 cycles, then one-cycle DONE with HI=0x00000000, LO=0x0000000F (unsigned build).
- A=0xFFFFFFFF, B=0xFFFFFFFF (unsigned) -> HI=0xFFFFFFFE, LO=0x00000001; verifies carry retention.
- START held high throughout the run, with A/B changed mid-run -> single DONE; result reflects the originally latched operands; next operation is accepted only after DONE.
- RST pulsed low at cycle 10 of RUN -> HI=LO=0, BUSY=0 asynchronously, no DONE. A subsequent A=7, B=6 yields LO=0x0000002A.
- MULT_SIGNED_EN: A=0xFFFFFFFD (-3), B=0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1, DONE 33 cycles after START.
- MULT_SIGNED_EN: A=0x80000000, B=0xFFFFFFFF -> HI=0x00000000, LO=0x80000000. A=0, B=0x80000000 -> HI=LO=0 (neg=1 with zero magnitude gives 0).
